control_command_tx: RTL and testbench

- Byte-stream initiator for the control command protocol: the transmit end that feeds the control unit's `in_byte`/`in_ready`/`next` interface.
- Accepts one decoded command request at a time (opcode, pipeline select, block, register, data, instruction) and serialises it into the exact byte sequence the control unit consumes.
- Used by the boot/preset loader and by verification benches, so that command sequences are generated rather than hand-built.
- Includes a per-byte acknowledge timeout and error reporting.

---
 rtl/control_command_tx_pkg.sv | 85 ++++++++
 rtl/control_command_tx_shifter.sv | 35 +++
 rtl/control_command_tx.sv | 186 ++++++++++++++++++
 tb/tb_control_command_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_command_tx_pkg.sv
// Shared definitions for the control command byte protocol: opcodes, field layout per opcode,
// field byte counts and the transmitter state encoding.
package control_command_tx_pkg;

  localparam int unsigned BlockRegAddrWidth = 4;
  localparam int unsigned BlockInstrWidth   = 32;
  localparam int unsigned InstrBytes        = BlockInstrWidth / 8;

  // The transmitted command byte carries the inverted pipeline select in this bit.
  localparam int unsigned PipelineBit = 3;

  localparam logic [7:0] CommandWriteBlockInstr = 8'h01;
  localparam logic [7:0] CommandWriteBlockReg   = 8'h02;
  localparam logic [7:0] CommandUpdateBlockReg  = 8'h03;
  localparam logic [7:0] CommandAllocSramDelay  = 8'h04;
  localparam logic [7:0] CommandSwapPipelines   = 8'h05;
  localparam logic [7:0] CommandResetPipeline   = 8'h06;

  typedef struct packed {
    logic has_block;
    logic has_reg;
    logic has_data;
    logic has_instr;
  } cmd_fields_t;

  typedef enum logic [2:0] {
    StIdle,
    StSendCmd,
    StSendBlock,
    StSendReg,
    StSendData,
    StSendInstr,
    StDrain
  } tx_state_e;

  function automatic int unsigned data_bytes(int unsigned data_width);
    return data_width / 8;
  endfunction

  // Which fields follow the command byte; unknown opcodes send the command byte only.
  function automatic cmd_fields_t decode_fields(logic [7:0] opcode);
    cmd_fields_t f;
    logic [7:0]  base;
    f                 = '0;
    base              = opcode;
    base[PipelineBit] = 1'b0;
    case (base)
      CommandWriteBlockInstr: begin
        f.has_block = 1'b1;
        f.has_instr = 1'b1;
      end
      CommandWriteBlockReg, CommandUpdateBlockReg: begin
        f.has_block = 1'b1;
        f.has_reg   = 1'b1;
        f.has_data  = 1'b1;
      end
      CommandAllocSramDelay: f.has_data = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  // Field order on the wire is cmd, block, reg, data, instr; absent fields are skipped.
  function automatic tx_state_e next_field(tx_state_e cur, cmd_fields_t f);
    tx_state_e nxt;
    nxt = StDrain;
    case (cur)
      StSendCmd: begin
        if (f.has_block)     nxt = StSendBlock;
        else if (f.has_data) nxt = StSendData;
      end
      StSendBlock: begin
        if (f.has_reg)        nxt = StSendReg;
        else if (f.has_instr) nxt = StSendInstr;
        else if (f.has_data)  nxt = StSendData;
      end
      StSendReg: begin
        if (f.has_data) nxt = StSendData;
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/control_command_tx_shifter.sv
// Holds one left-aligned field and presents its bytes MSB first; last flags the final byte.
module command_field_shifter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_word,
  input  logic [7:0]       load_count,
  input  logic             shift,
  output logic [7:0]       out_byte,
  output logic             last
);

  logic [Width-1:0] word_q;
  logic [7:0]       count_q;

  // Field register and remaining-byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      word_q  <= load_word;
      count_q <= load_count;
    end else if (shift) begin
      word_q  <= word_q << 8;
      count_q <= count_q - 8'd1;
    end
  end

  assign out_byte = word_q[Width-1 -: 8];
  assign last     = (count_q == 8'd0);

endmodule

// File: rtl/control_command_tx.sv
// Control command transmitter: serialises one command request into the byte stream consumed
// by the control unit, with per-byte acknowledge timeout and error reporting.
module control_command_tx
  import control_command_tx_pkg::*;
#(
  parameter int unsigned n_blocks       = 32,
  parameter int unsigned data_width     = 16,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_opcode,
  input  logic                         cmd_pipeline,
  input  logic [$clog2(n_blocks)-1:0]  cmd_block,
  input  logic [BlockRegAddrWidth-1:0] cmd_reg,
  input  logic [data_width-1:0]        cmd_data,
  input  logic [BlockInstrWidth-1:0]   cmd_instr,
  output logic [7:0]                   out_byte,
  output logic                         out_ready,
  input  logic                         next,
  input  logic                         invalid,
  output logic                         done,
  output logic                         error,
  output logic                         busy
);

  localparam int unsigned BlockWidth = $clog2(n_blocks);
  localparam int unsigned DataBytes  = data_bytes(data_width);
  localparam int unsigned ShiftWidth =
      (data_width > BlockInstrWidth) ? data_width : BlockInstrWidth;
  localparam int unsigned TimerWidth = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  tx_state_e                    state_q, state_d;
  logic [TimerWidth-1:0]        timer_q, timer_d;
  logic [1:0]                   drain_q, drain_d;
  logic                         error_q, error_d;
  cmd_fields_t                  fields_q;
  logic [BlockWidth-1:0]        block_q;
  logic [BlockRegAddrWidth-1:0] reg_q;
  logic [data_width-1:0]        data_q;
  logic [BlockInstrWidth-1:0]   instr_q;

  logic                  accept;
  logic                  sending;
  logic                  load;
  tx_state_e             load_sel;
  logic [ShiftWidth-1:0] load_word;
  logic [7:0]            load_count;
  logic                  shift;
  logic                  last;
  logic [7:0]            cmd_byte;

  assign accept  = (state_q == StIdle) && cmd_valid;
  assign sending = (state_q == StSendCmd) || (state_q == StSendBlock) ||
                   (state_q == StSendReg) || (state_q == StSendData) ||
                   (state_q == StSendInstr);

  // Command byte with the inverted pipeline select folded in.
  always_comb begin
    cmd_byte              = cmd_opcode;
    cmd_byte[PipelineBit] = cmd_opcode[PipelineBit] | ~cmd_pipeline;
  end

  // Left-align the field being loaded and give its byte count minus one.
  always_comb begin
    load_word  = '0;
    load_count = '0;
    case (load_sel)
      StSendCmd:   load_word = ShiftWidth'(cmd_byte) << (ShiftWidth - 8);
      StSendBlock: load_word = ShiftWidth'(block_q) << (ShiftWidth - 8);
      StSendReg:   load_word = ShiftWidth'(reg_q) << (ShiftWidth - 8);
      StSendData: begin
        load_word  = ShiftWidth'(data_q) << (ShiftWidth - data_width);
        load_count = 8'(DataBytes - 1);
      end
      StSendInstr: begin
        load_word  = ShiftWidth'(instr_q) << (ShiftWidth - BlockInstrWidth);
        load_count = 8'(InstrBytes - 1);
      end
      default: ;
    endcase
  end

  // Next-state, byte sequencing, timeout and drain control.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    drain_d  = drain_q;
    error_d  = invalid && (state_q != StIdle);
    load     = 1'b0;
    load_sel = StIdle;
    shift    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d  = StSendCmd;
          load     = 1'b1;
          load_sel = StSendCmd;
          timer_d  = '0;
        end
      end
      StSendCmd, StSendBlock, StSendReg, StSendData, StSendInstr: begin
        // An acknowledge beats a timeout expiring on the same edge.
        if (next) begin
          timer_d = '0;
          if (last) begin
            state_d = next_field(state_q, fields_q);
            if (state_d == StDrain) begin
              drain_d = '0;
            end else begin
              load     = 1'b1;
              load_sel = state_d;
            end
          end else begin
            shift = 1'b1;
          end
        end else if ((timeout_cycles != 0) &&
                     (timer_q == TimerWidth'(timeout_cycles - 1))) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDrain: begin
        // Two quiet cycles let a late invalid land before done.
        if (drain_q == 2'd2) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, error pulse and latched request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      drain_q  <= '0;
      error_q  <= 1'b0;
      fields_q <= '0;
      block_q  <= '0;
      reg_q    <= '0;
      data_q   <= '0;
      instr_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      drain_q <= drain_d;
      error_q <= error_d;
      if (accept) begin
        fields_q <= decode_fields(cmd_opcode);
        block_q  <= cmd_block;
        reg_q    <= cmd_reg;
        data_q   <= cmd_data;
        instr_q  <= cmd_instr;
      end
    end
  end

  command_field_shifter #(
    .Width(ShiftWidth)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_word (load_word),
    .load_count(load_count),
    .shift     (shift),
    .out_byte  (out_byte),
    .last      (last)
  );

  assign out_ready = sending;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign error     = error_q;

endmodule

// File: tb/tb_control_command_tx.sv
// Bench for control_command_tx: plays the control unit responder, checks the byte stream
// against a byte-list model and exercises timeout, invalid and reset corner cases.
module tb_control_command_tx;
  import control_command_tx_pkg::*;

  localparam int unsigned NBlocks   = 32;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned Timeout   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_pipeline;
  logic [7:0]  cmd_opcode;
  logic [4:0]  cmd_block;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic [31:0] cmd_instr;
  logic [7:0]  out_byte;
  logic        out_ready, next, invalid, done, error, busy;

  always #5 clk = ~clk;

  control_command_tx #(
    .n_blocks      (NBlocks),
    .data_width    (DataWidth),
    .timeout_cycles(Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_pipeline(cmd_pipeline),
    .cmd_block   (cmd_block),
    .cmd_reg     (cmd_reg),
    .cmd_data    (cmd_data),
    .cmd_instr   (cmd_instr),
    .out_byte    (out_byte),
    .out_ready   (out_ready),
    .next        (next),
    .invalid     (invalid),
    .done        (done),
    .error       (error),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  op;
    logic        pipe;
    logic [4:0]  blk;
    logic [3:0]  rg;
    logic [15:0] dat;
    logic [31:0] ins;
    int          nbytes;
    logic [47:0] bytes;
    bit          inj;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected byte list built directly from the protocol's field rules.
  function automatic void model_bytes(input logic [7:0] op, input logic pipe,
                                      input logic [4:0] blk, input logic [3:0] rg,
                                      input logic [15:0] dat, input logic [31:0] ins);
    logic [7:0] base;
    base = op & 8'hF7;
    exp_q.delete();
    exp_q.push_back(op | (pipe ? 8'h00 : 8'h08));
    if (base == 8'h01) begin
      exp_q.push_back(8'(blk));
      for (int i = 3; i >= 0; i--) exp_q.push_back(ins[8*i +: 8]);
    end else if (base == 8'h02 || base == 8'h03) begin
      exp_q.push_back(8'(blk));
      exp_q.push_back(8'(rg));
      exp_q.push_back(dat[15:8]);
      exp_q.push_back(dat[7:0]);
    end else if (base == 8'h04) begin
      exp_q.push_back(dat[15:8]);
      exp_q.push_back(dat[7:0]);
    end
  endfunction

  task automatic drive_cmd(input logic [7:0] op, input logic pipe, input logic [4:0] blk,
                           input logic [3:0] rg, input logic [15:0] dat,
                           input logic [31:0] ins, input string tag);
    cmd_opcode   = op;
    cmd_pipeline = pipe;
    cmd_block    = blk;
    cmd_reg      = rg;
    cmd_data     = dat;
    cmd_instr    = ins;
    cmd_valid    = 1'b1;
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
  endtask

  // Full transaction against exp_q; starts and ends just after a negedge.
  task automatic run_txn(input logic [7:0] op, input logic pipe, input logic [4:0] blk,
                         input logic [3:0] rg, input logic [15:0] dat, input logic [31:0] ins,
                         input bit inj, input int max_delay, input string tag);
    int n;
    int done_cyc, done_cnt, err_cnt, ready_cyc;
    n         = exp_q.size();
    done_cyc  = -1;
    done_cnt  = 0;
    err_cnt   = 0;
    ready_cyc = -1;
    drive_cmd(op, pipe, blk, rg, dat, ins, tag);
    for (int i = 0; i < n; i++) begin
      int d;
      // Requests while busy must be ignored.
      cmd_valid  = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_opcode = 8'($urandom);
      d = $urandom_range(0, max_delay);
      repeat (d) begin
        check($sformatf("%s hold%0d", tag, i), 64'(out_byte), 64'(exp_q[i]));
        @(negedge clk);
      end
      check($sformatf("%s ready%0d", tag, i), 64'(out_ready), 64'd1);
      check($sformatf("%s byte%0d", tag, i), 64'(out_byte), 64'(exp_q[i]));
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) check({tag, " drain out_ready"}, 64'(out_ready), 64'd0);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (error) err_cnt++;
      if (cmd_ready && ready_cyc < 0) ready_cyc = c;
      invalid = inj && (c == 0);
      next    = (c == 1);  // stray next while out_ready is low
      @(negedge clk);
      invalid = 1'b0;
      next    = 1'b0;
    end
    check({tag, " done count"}, 64'(done_cnt), 64'd1);
    check({tag, " done cycle"}, 64'(done_cyc), 64'd2);
    check({tag, " error count"}, 64'(err_cnt), inj ? 64'd1 : 64'd0);
    check({tag, " ready cycle"}, 64'(ready_cyc), 64'd3);
  endtask

  task automatic run_vec(input int k, input string tag);
    exp_q.delete();
    for (int j = 0; j < tbl[k].nbytes; j++)
      exp_q.push_back(tbl[k].bytes[8*(tbl[k].nbytes-1-j) +: 8]);
    run_txn(tbl[k].op, tbl[k].pipe, tbl[k].blk, tbl[k].rg, tbl[k].dat, tbl[k].ins,
            tbl[k].inj, 2, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[6];
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    tbl[0] = '{8'h02, 1'b0, 5'd5,  4'd3,  16'hBEEF, 32'h0,        5, 48'h000A0503BEEF, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 5'd31, 4'd0,  16'h0,    32'h12345678, 6, 48'h011F12345678, 1'b0};
    tbl[2] = '{8'h05, 1'b0, 5'd0,  4'd0,  16'h0,    32'h0,        1, 48'h00000000000D, 1'b0};
    tbl[3] = '{8'h06, 1'b1, 5'd7,  4'd2,  16'h1111, 32'h0,        1, 48'h000000000006, 1'b0};
    tbl[4] = '{8'h04, 1'b1, 5'd0,  4'd0,  16'h00A5, 32'h0,        3, 48'h0000000400A5, 1'b0};
    tbl[5] = '{8'h03, 1'b1, 5'd0,  4'd15, 16'h1234, 32'h0,        5, 48'h0003000F1234, 1'b0};
    tbl[6] = '{8'hF0, 1'b1, 5'd9,  4'd9,  16'h9999, 32'h0,        1, 48'h0000000000F0, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_pipeline = 1'b0;
    cmd_block = '0; cmd_reg = '0; cmd_data = '0; cmd_instr = '0;
    next = 1'b0; invalid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_ready", 64'(out_ready), 64'd0);
    check("reset out_byte", 64'(out_byte), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset error", 64'(error), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // invalid and next in IDLE are ignored
    invalid = 1'b1; next = 1'b1;
    @(negedge clk);
    invalid = 1'b0; next = 1'b0;
    check("idle error", 64'(error), 64'd0);
    check("idle out_ready", 64'(out_ready), 64'd0);
    check("idle cmd_ready", 64'(cmd_ready), 64'd1);

    for (int k = 0; k < 7; k++) run_vec(k, $sformatf("vec%0d", k));

    // Randomised requests against the byte-list model
    for (int r = 0; r < 24; r++) begin
      int k;
      logic [7:0] op;
      logic p;
      logic [4:0] b;
      logic [3:0] g;
      logic [15:0] d;
      logic [31:0] s;
      k = $urandom_range(0, 6);
      op = (k < 6) ? ops[k] : {4'($urandom_range(1, 15)), 4'b0000};
      p = 1'($urandom); b = 5'($urandom); g = 4'($urandom);
      d = 16'($urandom); s = $urandom;
      model_bytes(op, p, b, g, d, s);
      run_txn(op, p, b, g, d, s, k == 6, 3, $sformatf("rnd%0d", r));
    end

    // Timeout: responder never acknowledges
    begin
      int err_cyc, err_cnt, done_cnt;
      err_cyc = -1; err_cnt = 0; done_cnt = 0;
      drive_cmd(8'h05, 1'b1, 5'd0, 4'd0, 16'h0, 32'h0, "tmo");
      for (int c = 0; c < 40; c++) begin
        if (c == 15) check("tmo out_ready before expiry", 64'(out_ready), 64'd1);
        if (error) begin
          err_cnt++;
          if (err_cyc < 0) begin
            err_cyc = c;
            check("tmo out_ready at error", 64'(out_ready), 64'd0);
          end
        end
        if (done) done_cnt++;
        @(negedge clk);
      end
      check("tmo error cycle", 64'(err_cyc), 64'd16);
      check("tmo error count", 64'(err_cnt), 64'd1);
      check("tmo done count", 64'(done_cnt), 64'd0);
      run_vec(0, "after_tmo");
    end

    // Reset in the middle of an ALLOC_SRAM_DELAY
    model_bytes(8'h04, 1'b0, 5'd0, 4'd0, 16'h5A5A, 32'h0);
    drive_cmd(8'h04, 1'b0, 5'd0, 4'd0, 16'h5A5A, 32'h0, "rst");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst byte%0d", i), 64'(out_byte), 64'(exp_q[i]));
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
    end
    check("rst third byte ready", 64'(out_ready), 64'd1);
    reset = 1'b1;
    #1;
    check("rst async out_ready", 64'(out_ready), 64'd0);
    check("rst async busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst out_byte", 64'(out_byte), 64'd0);
    check("rst error", 64'(error), 64'd0);
    run_vec(0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
